// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM states and decode helpers for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Ops 0..3 go through the iterative datapath.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_twos_neg.sv
// Combinational conditional two's-complement negate; zero latency, no flow control.
module twos_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in_dat,
  output logic [W-1:0] out_dat
);

  assign out_dat = neg ? (~in_dat + W'(1)) : in_dat;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; done lands N+2 cycles after accept.
// start is ignored while busy; flush aborts an in-flight op without touching HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam int PW = WIDTH + MUL_BPC;
  localparam logic [CW-1:0] N_MUL = CW'(WIDTH / MUL_BPC);
  localparam logic [CW-1:0] N_DIV = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  twos_neg #(.W(WIDTH)) u_neg_a (
    .neg(is_signed(op) & a[WIDTH-1]), .in_dat(a), .out_dat(a_mag));
  twos_neg #(.W(WIDTH)) u_neg_b (
    .neg(is_signed(op) & b[WIDTH-1]), .in_dat(b), .out_dat(b_mag));
  twos_neg #(.W(2*WIDTH)) u_neg_prod (
    .neg(neg_lo_q), .in_dat(acc_q[2*WIDTH-1:0]), .out_dat(prod_fix));
  twos_neg #(.W(WIDTH)) u_neg_quo (
    .neg(neg_lo_q), .in_dat(acc_q[WIDTH-1:0]), .out_dat(quo_fix));
  twos_neg #(.W(WIDTH)) u_neg_rem (
    .neg(neg_hi_q), .in_dat(acc_q[2*WIDTH-1:WIDTH]), .out_dat(rem_fix));

  // Multiply step: add multiplicand * low digit into the upper half, then shift right.
  logic [MUL_BPC-1:0] digit;
  logic [PW-1:0]      pp;
  logic [PW:0]        msum;
  logic [AW-1:0]      mul_next;
  // Divide step: restoring shift-subtract on {remainder(W+1), quotient(W)}.
  logic [AW-1:0]      sh;
  logic [WIDTH+1:0]   diff;
  logic [AW-1:0]      div_next;

  always_comb begin
    digit    = acc_q[MUL_BPC-1:0];
    pp       = PW'(opd_q) * PW'(digit);
    msum     = (PW+1)'(acc_q[AW-1:WIDTH]) + (PW+1)'(pp);
    mul_next = AW'({msum, acc_q[WIDTH-1:0]} >> MUL_BPC);
    sh       = {acc_q[AW-2:0], 1'b0};
    diff     = {1'b0, sh[AW-1:WIDTH]} - {2'b00, opd_q};
    div_next = diff[WIDTH+1] ? sh : {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (is_muldiv(op)) begin
            state_d  = ST_RUN;
            div_d    = is_div(op);
            cnt_d    = is_div(op) ? N_DIV : N_MUL;
            acc_d    = {{(WIDTH+1){1'b0}}, a_mag};
            opd_d    = b_mag;
            neg_lo_d = is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_d = is_signed(op) & a[WIDTH-1];
            dbz_d    = 1'b0;
          end else if (op == OP_MTHI) begin
            hi_d   = a;
            done_d = 1'b1;
            dbz_d  = 1'b0;
          end else if (op == OP_MTLO) begin
            lo_d   = a;
            done_d = 1'b1;
            dbz_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (opd_q == '0) begin
            // Zero divisor leaves |a| as remainder; re-signing it restores raw a.
            hi_d  = rem_fix;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit, run side by side at MUL_BPC=1 and MUL_BPC=4.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush1 = 1'b0;
  logic        flush4 = 1'b0;

  logic        busy1, done1, dbz1, busy4, done4, dbz4;
  logic [31:0] hi1, lo1, hi4, lo4;

  muldiv_unit #(.WIDTH(32), .MUL_BPC(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i), .flush(flush1),
    .busy(busy1), .done(done1), .div_by_zero(dbz1), .hi(hi1), .lo(lo1));

  muldiv_unit #(.WIDTH(32), .MUL_BPC(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i), .flush(flush4),
    .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          lat1, lat4;
  logic [31:0] rh1, rl1, rh4, rl4;
  logic        rz1, rz4, rb1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the cycle right after the accept edge; latency is the cycle in which done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    op_i = o; a_i = av; b_i = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = -1; lat4 = -1;
    for (int c = 1; c <= 60 && (lat1 < 0 || lat4 < 0); c++) begin
      if (done1 && lat1 < 0) begin lat1 = c; rh1 = hi1; rl1 = lo1; rz1 = dbz1; rb1 = busy1; end
      if (done4 && lat4 < 0) begin lat4 = c; rh4 = hi4; rl4 = lo4; rz4 = dbz4; end
      if (lat1 < 0 || lat4 < 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int  seen_done;
    logic b1_10, b1_11, b4_9, b4_10;

    #2 rst = 1'b0;
    #20;
    check("rst_busy", {busy1, busy4}, 2'b00);
    check("rst_done", {done1, done4}, 2'b00);
    check("rst_dbz", {dbz1, dbz4}, 2'b00);
    check("rst_hi", {hi1, hi4}, 64'h0);
    check("rst_lo", {lo1, lo4}, 64'h0);
    @(negedge clk); rst = 1'b1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_lat1", lat1, 34);
    check("multu_lat4", lat4, 10);
    check("multu_hilo1", {rh1, rl1}, 64'hFFFF_FFFE_0000_0001);
    check("multu_hilo4", {rh4, rl4}, 64'hFFFF_FFFE_0000_0001);
    check("multu_busy_at_done", rb1, 1'b0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_lat4", lat4, 10);
    check("mult_hilo1", {rh1, rl1}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mult_hilo4", {rh4, rl4}, 64'hFFFF_FFFF_FFFF_FFF1);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lat1", lat1, 34);
    check("div_lat4", lat4, 34);
    check("div_hilo1", {rh1, rl1}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_hilo4", {rh4, rl4}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(OP_DIVU, 32'd100, 32'd7);
    check("divu_hilo1", {rh1, rl1}, {32'd2, 32'd14});

    run_op(OP_DIVU, 32'd7, 32'd0);
    check("dbz_lat1", lat1, 34);
    check("dbz_hilo1", {rh1, rl1}, {32'd7, 32'hFFFF_FFFF});
    check("dbz_flag", {rz1, rz4}, 2'b11);

    run_op(OP_MTLO, 32'h0000_1234, 32'd0);
    check("mtlo_lat", {lat1[7:0], lat4[7:0]}, 16'h0101);
    check("mtlo_busy", rb1, 1'b0);
    check("mtlo_lo", {rl1, rl4}, {32'h1234, 32'h1234});
    check("mtlo_dbz_clear", {rz1, rz4}, 2'b00);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_hilo1", {rh1, rl1}, 64'h0000_0000_8000_0000);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    check("sdiv_dbz_hilo1", {rh1, rl1}, 64'hFFFF_FFF9_FFFF_FFFF);

    run_op(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("rsvd_no_done", lat1, -1);
    check("rsvd_hilo1", {hi1, lo1}, 64'hFFFF_FFF9_FFFF_FFFF);

    run_op(OP_MTHI, 32'h0000_AAAA, 32'd0);
    run_op(OP_MTLO, 32'h0000_1234, 32'd0);

    // Flush: full-rate unit in RUN at cycle 10, BPC=4 unit in FIX at cycle 9.
    @(negedge clk);
    op_i = OP_MULT; a_i = 32'd3; b_i = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 0;
    b1_10 = 1'b0; b1_11 = 1'b1; b4_9 = 1'b0; b4_10 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (done1 || done4) seen_done++;
      if (c == 10) b1_10 = busy1;
      if (c == 11) b1_11 = busy1;
      if (c == 9)  b4_9  = busy4;
      if (c == 10) b4_10 = busy4;
      flush4 = (c == 9);
      flush1 = (c == 10);
      @(posedge clk); #1;
    end
    flush1 = 1'b0; flush4 = 1'b0;
    check("flush_busy_before", {b1_10, b4_9}, 2'b11);
    check("flush_busy_after", {b1_11, b4_10}, 2'b00);
    check("flush_no_done", seen_done, 0);
    check("flush_hilo1", {hi1, lo1}, 64'h0000_AAAA_0000_1234);
    check("flush_hilo4", {hi4, lo4}, 64'h0000_AAAA_0000_1234);

    run_op(OP_MULT, 32'd3, 32'd4);
    check("restart_lat1", lat1, 34);
    check("restart_hilo1", {rh1, rl1}, 64'd12);
    check("restart_hilo4", {rh4, rl4}, 64'd12);

    // A start pulse while busy must be dropped.
    @(negedge clk);
    op_i = OP_MULT; a_i = 32'd6; b_i = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = -1; lat4 = -1;
    for (int c = 1; c <= 60 && lat1 < 0; c++) begin
      if (c == 5) begin op_i = OP_MTHI; a_i = 32'h55; start = 1'b1; end
      if (c == 6) start = 1'b0;
      if (done1 && lat1 < 0) begin lat1 = c; rh1 = hi1; rl1 = lo1; end
      if (done4 && lat4 < 0) begin lat4 = c; rh4 = hi4; rl4 = lo4; end
      if (lat1 < 0) begin @(posedge clk); #1; end
    end
    check("busy_start_lat1", lat1, 34);
    check("busy_start_hilo1", {rh1, rl1}, 64'd42);
    check("busy_start_hilo4", {rh4, rl4}, 64'd42);
    check("busy_start_final_hi", {hi1, hi4}, 64'h0);

    // Asynchronous reset mid-divide, checked between clock edges.
    @(negedge clk);
    op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {busy1, busy4}, 2'b00);
    check("arst_done", {done1, done4}, 2'b00);
    check("arst_hilo1", {hi1, lo1}, 64'h0);
    check("arst_hilo4", {hi4, lo4}, 64'h0);
    @(negedge clk); rst = 1'b1;

    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    check("post_rst_hilo1", {rh1, rl1}, 64'h0000_0001_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
